detector_jogada: RTL and testbench

// - Input conditioner upstream of the game datapath/control of circuito_exp4.
// - Synchronises and debounces the 4 player switches (chaves).
// - Validates one-hot plays and emits one registered jogada plus a 1-cycle tem_jogada strobe per press.
// - A switch must return to all-zero before another play is accepted.
// - Control unit gates detection with habilita; limpa clears the stored play.

---
 rtl/detector_jogada_pkg.sv | 16 +
 rtl/detector_jogada_sincronizador.sv | 24 ++
 rtl/detector_jogada.sv | 126 ++++++++++++
 tb/tb_detector_jogada.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the play detector: default sizes and FSM state codes.
package detector_jogada_pkg;

   localparam int WIDTH_DEF    = 4;
   localparam int DEBOUNCE_DEF = 3;

   // Codes are visible on db_estado, so they are fixed explicitly.
   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      FILTRA        = 3'd1,
      REGISTRA      = 3'd2,
      ESPERA_SOLTAR = 3'd3,
      FILTRA_SOLTAR = 3'd4
   } estado_t;

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Two-flop synchroniser for asynchronous level inputs (switches, buttons).
module detector_jogada_sincronizador #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture; meta may go metastable, q is the settled copy.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/detector_jogada.sv
// Player switch conditioner: synchronises and debounces the switches, accepts
// only one-hot plays, emits one tem_jogada pulse per press and requires a
// debounced release before the next play.
//
// state         | meaning
// OCIOSO        | idle, waiting for a non-zero pattern while habilita
// FILTRA        | pattern must stay equal to cand for DEBOUNCE_CYCLES samples
// REGISTRA      | one cycle: capture (one-hot) or reject (not one-hot)
// ESPERA_SOLTAR | waiting for all switches to read zero
// FILTRA_SOLTAR | zero must persist DEBOUNCE_CYCLES samples before idling
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             habilita,
   input  logic             limpa,
   input  logic [WIDTH-1:0] chaves,
   output logic [WIDTH-1:0] jogada_feita,
   output logic             tem_jogada,
   output logic             jogada_invalida,
   output logic [2:0]       db_estado
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   estado_t          estado, estado_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [WIDTH-1:0] cand, cand_next;
   logic [WIDTH-1:0] s;
   logic             cand_onehot;

   detector_jogada_sincronizador #(.WIDTH(WIDTH)) u_sinc (
      .clock (clock),
      .reset (reset),
      .d     (chaves),
      .q     (s)
   );

   assign cand_onehot = $onehot(cand);
   assign db_estado   = estado;

   // State, debounce counter and candidate pattern registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= OCIOSO;
         cnt    <= '0;
         cand   <= '0;
      end else begin
         estado <= estado_next;
         cnt    <= cnt_next;
         cand   <= cand_next;
      end
   end

   // Next-state logic and Moore strobes (decoded only from registered state).
   always_comb begin
      estado_next     = estado;
      cnt_next        = cnt;
      cand_next       = cand;
      tem_jogada      = 1'b0;
      jogada_invalida = 1'b0;
      case (estado)
         OCIOSO: begin
            if (habilita && (s != '0)) begin
               cand_next   = s;
               cnt_next    = CNT_ONE;
               estado_next = FILTRA;
            end
         end
         FILTRA: begin
            if (!habilita || (s == '0)) begin
               estado_next = OCIOSO;
            end else if (s != cand) begin
               cand_next = s;
               cnt_next  = CNT_ONE;
            end else if (cnt >= CNT_MAX) begin
               estado_next = REGISTRA;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         REGISTRA: begin
            tem_jogada      = cand_onehot;
            jogada_invalida = !cand_onehot;
            estado_next     = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            // habilita is deliberately ignored so a held switch cannot re-fire.
            if (s == '0) begin
               cnt_next    = CNT_ONE;
               estado_next = FILTRA_SOLTAR;
            end
         end
         FILTRA_SOLTAR: begin
            if (s != '0) begin
               estado_next = ESPERA_SOLTAR;
            end else if (cnt >= CNT_MAX) begin
               estado_next = OCIOSO;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         default: begin
            estado_next = OCIOSO;
         end
      endcase
   end

   // Stored play; limpa wins over a capture in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         jogada_feita <= '0;
      end else if (limpa) begin
         jogada_feita <= '0;
      end else if (tem_jogada) begin
         jogada_feita <= cand;
      end
   end

endmodule

// File: tb/tb_detector_jogada.sv
`timescale 1us/1ns
module tb_detector_jogada;

   logic       clock = 1'b0;
   logic       reset;
   logic       habilita;
   logic       limpa;
   logic [3:0] chaves;
   logic [3:0] jogada_feita;
   logic       tem_jogada;
   logic       jogada_invalida;
   logic [2:0] db_estado;

   int n_checks = 0;
   int n_fail   = 0;
   int n_tem    = 0;
   int n_inv    = 0;

   int est_press[10]   = '{0, 0, 1, 1, 1, 2, 3, 3, 3, 3};
   int est_release[7]  = '{3, 3, 4, 4, 4, 0, 0};

   detector_jogada #(.WIDTH(4), .DEBOUNCE_CYCLES(3)) dut (
      .clock           (clock),
      .reset           (reset),
      .habilita        (habilita),
      .limpa           (limpa),
      .chaves          (chaves),
      .jogada_feita    (jogada_feita),
      .tem_jogada      (tem_jogada),
      .jogada_invalida (jogada_invalida),
      .db_estado       (db_estado)
   );

   always #500 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n falling edges, tallying strobes seen on the way.
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock);
         if (tem_jogada === 1'b1) n_tem++;
         if (jogada_invalida === 1'b1) n_inv++;
      end
   endtask

   initial begin
      reset    = 1'b0;
      habilita = 1'b0;
      limpa    = 1'b0;
      chaves   = 4'b0000;
      step(2);
      chk("rst_estado", db_estado, 0);
      chk("rst_jogada", jogada_feita, 0);
      chk("rst_tem", tem_jogada, 0);
      chk("rst_inv", jogada_invalida, 0);
      reset = 1'b1;
      step(2);

      // Clean press of 0001: tem_jogada 2+3 edges after first sample.
      habilita = 1'b1;
      chaves   = 4'b0001;
      n_tem = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk($sformatf("p1_estado_%0d", i), db_estado, est_press[i]);
         chk($sformatf("p1_tem_%0d", i), tem_jogada, (i == 5) ? 1 : 0);
      end
      chk("p1_jogada", jogada_feita, 4'b0001);
      chk("p1_ntem", n_tem, 1);
      chaves = 4'b0000;
      for (int i = 0; i < 7; i++) begin
         step(1);
         chk($sformatf("p1_rel_estado_%0d", i), db_estado, est_release[i]);
      end

      // 2-cycle glitch of 0100 is ignored.
      n_tem = 0;
      chaves = 4'b0100;
      step(2);
      chaves = 4'b0000;
      step(8);
      chk("glitch_ntem", n_tem, 0);
      chk("glitch_jogada", jogada_feita, 4'b0001);
      chk("glitch_estado", db_estado, 0);

      // Non-one-hot 0011 is rejected once.
      n_tem = 0;
      n_inv = 0;
      chaves = 4'b0011;
      step(10);
      chk("inv_ninv", n_inv, 1);
      chk("inv_ntem", n_tem, 0);
      chk("inv_jogada", jogada_feita, 4'b0001);
      chaves = 4'b0000;
      step(8);
      chk("inv_rel_estado", db_estado, 0);

      // Long hold of 1000 fires once only.
      n_tem = 0;
      chaves = 4'b1000;
      step(3200);
      chk("hold_ntem", n_tem, 1);
      chk("hold_jogada", jogada_feita, 4'b1000);
      chk("hold_estado", db_estado, 3);

      // Async reset while still held, then the held switch counts as a new press.
      reset = 1'b0;
      #1;
      chk("mrst_estado", db_estado, 0);
      chk("mrst_jogada", jogada_feita, 0);
      chk("mrst_tem", tem_jogada, 0);
      chk("mrst_inv", jogada_invalida, 0);
      step(1);
      reset = 1'b1;
      n_tem = 0;
      step(10);
      chk("mrst_ntem", n_tem, 1);
      chk("mrst_jogada2", jogada_feita, 4'b1000);
      chk("mrst_estado2", db_estado, 3);
      chaves = 4'b0000;
      step(2);
      chaves = 4'b1000;
      step(4);
      chk("bounce_ntem", n_tem, 1);
      chaves = 4'b0000;
      step(8);
      chk("mrst_rel_estado", db_estado, 0);

      // habilita drop during FILTRA aborts.
      n_tem = 0;
      chaves = 4'b0001;
      step(3);
      chk("abort_filtra", db_estado, 1);
      habilita = 1'b0;
      step(1);
      chk("abort_estado", db_estado, 0);
      step(6);
      chk("abort_ntem", n_tem, 0);
      chk("abort_jogada", jogada_feita, 4'b1000);
      chaves = 4'b0000;
      step(3);

      // Disabled press, then enable with limpa in the REGISTRA cycle.
      chaves = 4'b0010;
      step(10);
      chk("dis_ntem", n_tem, 0);
      chk("dis_estado", db_estado, 0);
      chk("dis_jogada", jogada_feita, 4'b1000);
      habilita = 1'b1;
      step(3);
      chk("lim_filtra", db_estado, 1);
      step(1);
      chk("lim_registra", db_estado, 2);
      chk("lim_tem", tem_jogada, 1);
      limpa = 1'b1;
      step(1);
      limpa = 1'b0;
      chk("lim_jogada", jogada_feita, 4'b0000);
      chk("lim_estado", db_estado, 3);
      chaves = 4'b0000;
      step(8);
      chk("end_estado", db_estado, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
